// File: rtl/arbitro_mux8.sv
// Round-robin 2:1 arbiter for the shared select path: picks one requester, registers its word
// and hands it downstream over a valid/ready handshake.
//
// state  | meaning
// OCIOSO | output register empty, saida_valid=0
// CHEIO  | output register holds an untaken word, saida_valid=1
module arbitro_mux8 #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] entr0,
    input  logic [WIDTH-1:0] entr1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] saida,
    output logic             saida_valid,
    input  logic             pronto,
    output logic             sinalt1,
    output logic [CNTW-1:0]  cnt0,
    output logic [CNTW-1:0]  cnt1
);

    typedef enum logic {OCIOSO, CHEIO} estado_t;

    estado_t estado;
    logic    ultimo;
    logic    livre;
    logic    captura;
    logic    escolha;

    // A full register with pronto high drains and refills in the same cycle.
    always_comb begin
        livre   = (estado == OCIOSO) || pronto;
        captura = livre && (req0 || req1) && !rst;
        escolha = req1 && (!req0 || !ultimo);
    end

    assign gnt0        = captura && !escolha;
    assign gnt1        = captura && escolha;
    assign saida_valid = (estado == CHEIO);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= OCIOSO;
            saida   <= '0;
            sinalt1 <= 1'b0;
            ultimo  <= 1'b1;
            cnt0    <= '0;
            cnt1    <= '0;
        end else if (captura) begin
            estado  <= CHEIO;
            saida   <= escolha ? entr1 : entr0;
            sinalt1 <= escolha;
            ultimo  <= escolha;
            if (escolha)
                cnt1 <= cnt1 + 1'b1;
            else
                cnt0 <= cnt0 + 1'b1;
        end else if (estado == CHEIO && pronto) begin
            estado <= OCIOSO;
        end
    end

endmodule
